// File: rtl/clkgen_multi_pkg.sv
// Shared types and constants for the multi-output clock-enable generator.
// Channel config bundle plus the default audio ratio (22/105 of CLK).
package clkgen_multi_pkg;

  localparam int CLKGEN_ACC_W   = 8;
  localparam int CLKGEN_NCH     = 2;
  localparam int CLKGEN_AUD_MUL = 22;
  localparam int CLKGEN_AUD_DIV = 105;

  typedef struct packed {
    logic [CLKGEN_ACC_W-1:0] mul;
    logic [CLKGEN_ACC_W-1:0] div;
  } clkgen_ch_cfg_t;

endpackage

// File: rtl/clkgen_multi_if.sv
// Control inputs and strobe outputs of clkgen_multi.
// master drives run/sync/ratios; slave is the generator.
interface clkgen_multi_if #(
  parameter int NCH   = 2,
  parameter int ACC_W = 8
);
  logic                 EN;
  logic                 SYNC;
  logic [NCH*ACC_W-1:0] MUL;
  logic [NCH*ACC_W-1:0] DIV;
  logic                 CP1_POSEDGE;
  logic                 CP1_NEGEDGE;
  logic                 CP2_POSEDGE;
  logic                 CP2_NEGEDGE;
  logic                 VDC_CE;
  logic [NCH-1:0]       CE;
  logic [NCH-1:0]       CFG_ERR;

  modport master (
    output EN, SYNC, MUL, DIV,
    input  CP1_POSEDGE, CP1_NEGEDGE,
    input  CP2_POSEDGE, CP2_NEGEDGE,
    input  VDC_CE, CE, CFG_ERR
  );

  modport slave (
    input  EN, SYNC, MUL, DIV,
    output CP1_POSEDGE, CP1_NEGEDGE,
    output CP2_POSEDGE, CP2_NEGEDGE,
    output VDC_CE, CE, CFG_ERR
  );
endinterface

// File: rtl/clkgen_multi_frac_ch.sv
// One fractional MUL/DIV clock-enable channel.
// CE is zero-latency: it compares against the current accumulator.
module clkgen_frac_ch #(
  parameter int ACC_W = 8
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             EN,
  input  logic             SYNC,
  input  logic [ACC_W-1:0] MUL,
  input  logic [ACC_W-1:0] DIV,
  output logic             CE,
  output logic             CFG_ERR
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] accr;
  logic [ACC_W:0]   accn;
  logic             run;
  logic             stale;

  always_comb begin
    accn    = {1'b0, acc_q} + {1'b0, MUL};
    accr    = accn[ACC_W-1:0] - DIV;
    run     = EN & ~RES & ~SYNC;
    CFG_ERR = (DIV == '0) | (MUL > DIV);
    // acc left over from a larger DIV would otherwise burst
    stale   = (acc_q >= DIV);
    CE      = run & ~CFG_ERR & ~stale
            & (accn >= {1'b0, DIV});
    acc_d   = acc_q;
    if (SYNC || CFG_ERR) begin
      acc_d = '0;
    end else if (EN) begin
      if (stale)   acc_d = '0;
      else if (CE) acc_d = accr;
      else         acc_d = accn[ACC_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/clkgen_multi.sv
// CPU 2-phase edge strobes and VDC CE from a modulo phase counter,
// plus NCH fractional clock-enable channels.
module clkgen_multi
  import clkgen_multi_pkg::*;
#(
  parameter int CPU_DIV = 14,
  parameter int P1R     = 2,
  parameter int P1F     = 4,
  parameter int P2R     = 6,
  parameter int VDC_PH0 = 2,
  parameter int VDC_PH1 = 9,
  parameter int NCH     = CLKGEN_NCH,
  parameter int ACC_W   = CLKGEN_ACC_W
) (
  input  logic          CLK,
  input  logic          RES,
  clkgen_multi_if.slave bus
);
  localparam int CW = $clog2(CPU_DIV);
  localparam logic [CW-1:0] LAST = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0] C1R  = CW'(P1R);
  localparam logic [CW-1:0] C1F  = CW'(P1F);
  localparam logic [CW-1:0] C2R  = CW'(P2R);
  localparam logic [CW-1:0] CV0  = CW'(VDC_PH0);
  localparam logic [CW-1:0] CV1  = CW'(VDC_PH1);

  if (CPU_DIV < 4) begin : g_bad_div
    $error("clkgen_multi: CPU_DIV must be >= 4");
  end
  if (P1R >= CPU_DIV || P1F >= CPU_DIV || P2R >= CPU_DIV ||
      VDC_PH0 >= CPU_DIV || VDC_PH1 >= CPU_DIV) begin : g_bad_ph
    $error("clkgen_multi: phase outside CPU_DIV");
  end
  if (P1R == 0 || P1F == 0 || P2R == 0 ||
      P1R == P1F || P1R == P2R || P1F == P2R) begin : g_bad_cpu
    $error("clkgen_multi: CPU phases must be distinct and nonzero");
  end

  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          run;

  always_comb begin
    run    = bus.EN & ~RES & ~bus.SYNC;
    ccnt_d = ccnt_q;
    if (bus.SYNC) begin
      ccnt_d = '0;
    end else if (bus.EN) begin
      ccnt_d = (ccnt_q == LAST) ? '0 : ccnt_q + CW'(1);
    end
    bus.CP2_NEGEDGE = run & (ccnt_q == '0);
    bus.CP1_POSEDGE = run & (ccnt_q == C1R);
    bus.CP1_NEGEDGE = run & (ccnt_q == C1F);
    bus.CP2_POSEDGE = run & (ccnt_q == C2R);
    bus.VDC_CE      = run & ((ccnt_q == CV0) | (ccnt_q == CV1));
  end

  always_ff @(posedge CLK) begin
    if (RES) ccnt_q <= '0;
    else     ccnt_q <= ccnt_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkgen_frac_ch #(.ACC_W(ACC_W)) u_ch (
      .CLK     (CLK),
      .RES     (RES),
      .EN      (bus.EN),
      .SYNC    (bus.SYNC),
      .MUL     (bus.MUL[i*ACC_W +: ACC_W]),
      .DIV     (bus.DIV[i*ACC_W +: ACC_W]),
      .CE      (bus.CE[i]),
      .CFG_ERR (bus.CFG_ERR[i])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: phase strobes, fractional CEs,
// pause, sync, config errors and runtime ratio change.
module tb_clkgen_multi;
  import clkgen_multi_pkg::*;

  logic clk = 1'b0;
  logic res;

  clkgen_multi_if #(.NCH(2), .ACC_W(8)) bus ();

  clkgen_multi u_dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ph     = 0;
  int tick   = 0;
  int last0, min_sp, max_sp;
  int n_cp2n, n_cp1p, n_cp1n, n_cp2p, n_vdc, n_ce0, n_ce1;
  logic [31:0] h0 = '0;
  logic [31:0] h1 = '0;
  logic [4:0]  s_last;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_cp2n = 0; n_cp1p = 0; n_cp1n = 0; n_cp2p = 0;
    n_vdc  = 0; n_ce0  = 0; n_ce1  = 0;
  endtask

  // Drive one cycle, check strobes against the reference phase, count.
  task automatic cyc(input logic en_i, input logic sy_i,
                     input logic rs_i);
    logic       g;
    logic [4:0] s, e;
    int         sp;
    bus.EN = en_i; bus.SYNC = sy_i; res = rs_i;
    @(negedge clk);
    g = en_i & ~sy_i & ~rs_i;
    s = {bus.CP2_NEGEDGE, bus.CP1_POSEDGE, bus.CP1_NEGEDGE,
         bus.CP2_POSEDGE, bus.VDC_CE};
    e = g ? {ph == 0, ph == 2, ph == 4, ph == 6,
             (ph == 2) || (ph == 9)} : 5'b0;
    check("strobes", s, e);
    if (!g) check("ce_gated", bus.CE, 0);
    s_last = s;
    n_cp2n += s[4]; n_cp1p += s[3]; n_cp1n += s[2];
    n_cp2p += s[1]; n_vdc  += s[0];
    n_ce0  += bus.CE[0]; n_ce1 += bus.CE[1];
    h0 = {h0[30:0], bus.CE[0]};
    h1 = {h1[30:0], bus.CE[1]};
    if (bus.CE[0]) begin
      if (last0 >= 0) begin
        sp = tick - last0;
        if (sp < min_sp) min_sp = sp;
        if (sp > max_sp) max_sp = sp;
      end
      last0 = tick;
    end
    if (rs_i || sy_i)  ph = 0;
    else if (en_i)     ph = (ph == 13) ? 0 : ph + 1;
    tick++;
    @(posedge clk); #1;
  endtask

  initial begin
    res = 1'b1; bus.EN = 1'b0; bus.SYNC = 1'b0;
    bus.MUL = {8'd1, 8'(CLKGEN_AUD_MUL)};
    bus.DIV = {8'd3, 8'(CLKGEN_AUD_DIV)};
    last0 = -1; min_sp = 1000; max_sp = 0;
    clr();
    @(posedge clk); #1;

    // reset with EN high: everything gated
    repeat (3) cyc(1, 0, 1);
    check("cfg_err_reset", bus.CFG_ERR, 0);

    // 140 free-running cycles
    clr();
    repeat (140) cyc(1, 0, 0);
    check("vdc_count", n_vdc, 20);
    check("cp2n_count", n_cp2n, 10);
    check("cp1p_count", n_cp1p, 10);
    check("cp1n_count", n_cp1n, 10);
    check("cp2p_count", n_cp2p, 10);

    // fractional ratios over 1050 cycles
    cyc(1, 1, 0);
    clr(); last0 = -1; min_sp = 1000; max_sp = 0;
    repeat (1050) cyc(1, 0, 0);
    check("ce0_count", n_ce0, 220);
    check("ce1_count", n_ce1, 350);
    check("ce0_min_sp", min_sp, 4);
    check("ce0_max_sp", max_sp, 5);

    // SYNC at phase 9 while acc0=93 (CE0 would fire)
    repeat (9) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("sync_strobes", s_last, 0);
    check("sync_ce", {h1[0], h0[0]}, 0);
    cyc(1, 0, 0);
    check("sync_cp2n", s_last[4], 1);
    repeat (4) cyc(1, 0, 0);
    check("sync_ce0_first", h0[4:0], 5'b00001);
    check("sync_ce1_first", h1[4:0], 5'b00100);

    // pause after 7 enabled cycles for 20 cycles
    cyc(1, 1, 0);
    clr();
    repeat (7) cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    check("pause_vdc", n_vdc, 1);
    check("pause_ce0", n_ce0, 1);
    repeat (133) cyc(1, 0, 0);
    check("resume_vdc", n_vdc, 20);
    check("resume_cp2n", n_cp2n, 10);
    check("resume_cp2p", n_cp2p, 10);
    check("resume_ce0", n_ce0, 29);
    check("resume_ce1", n_ce1, 46);

    // MUL=0: acc0 holds at 35, no CE
    bus.MUL[7:0] = 8'd0;
    clr();
    repeat (20) cyc(1, 0, 0);
    check("mul0_ce", n_ce0, 0);
    check("mul0_cfg", bus.CFG_ERR, 0);

    // MUL>DIV: error, no CE, acc cleared
    bus.MUL[7:0] = 8'd8; bus.DIV[7:0] = 8'd7;
    clr();
    repeat (5) cyc(1, 0, 0);
    check("mulgt_cfg", bus.CFG_ERR, 2'b01);
    check("mulgt_ce", n_ce0, 0);

    // 1/3 from a cleared acc: CE on the third cycle
    bus.MUL[7:0] = 8'd1; bus.DIV[7:0] = 8'd3;
    repeat (3) cyc(1, 0, 0);
    check("acc_cleared", h0[2:0], 3'b001);

    // MUL=DIV: CE every cycle
    bus.MUL[7:0] = 8'd7; bus.DIV[7:0] = 8'd7;
    clr();
    repeat (10) cyc(1, 0, 0);
    check("muleq_ce", n_ce0, 10);
    check("muleq_cfg", bus.CFG_ERR, 0);

    // DIV=0
    bus.MUL[7:0] = 8'd5; bus.DIV[7:0] = 8'd0;
    clr();
    repeat (4) cyc(1, 0, 0);
    check("div0_cfg", bus.CFG_ERR, 2'b01);
    check("div0_ce", n_ce0, 0);

    // runtime change 22/105 -> 22/50 at acc0=100
    bus.MUL[7:0] = 8'd22; bus.DIV[7:0] = 8'd105;
    cyc(1, 1, 0);
    clr();
    repeat (100) cyc(1, 0, 0);
    check("pre_change_ce0", n_ce0, 20);
    bus.DIV[7:0] = 8'd50;
    clr();
    cyc(1, 0, 0);
    check("change_no_burst", h0[0], 0);
    repeat (100) cyc(1, 0, 0);
    check("ratio_22_50", n_ce0, 44);
    check("ratio_cfg", bus.CFG_ERR, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
